// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART framers: state encoding and parity helper.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam logic LineIdle = 1'b1;

  // Data is zero-padded to 8 bits; padding does not change the XOR reduction.
  function automatic logic calc_perr(input logic [7:0] data, input logic par_bit,
                                     input logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_frame_sync.sv
// Two-flop synchroniser for the RX pin plus an edge flop for start-edge detection.
module uart_rx_frame_sync
  import uart_rx_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  output logic rxd,
  output logic fall
);

  logic meta_q, rxd_q, rxd_dly_q;

  // Reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= LineIdle;
      rxd_q     <= LineIdle;
      rxd_dly_q <= LineIdle;
    end else begin
      meta_q    <= rx_pin;
      rxd_q     <= meta_q;
      rxd_dly_q <= rxd_q;
    end
  end

  assign rxd  = rxd_q;
  assign fall = rxd_dly_q & ~rxd_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling on clk_bps, LSB-first assembly.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);

  logic rxd, fall;

  uart_rx_frame_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .rxd    (rxd),
    .fall   (fall)
  );

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 bps_q, bps_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_out_q, perr_out_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q;
    data_d     = data_q;
    bps_d      = bps_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_out_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // clk_bps is meaningless here; only the synchronised falling edge matters.
        if (fall) begin
          state_d = StStart;
          bps_d   = 1'b1;
        end
      end
      StStart: begin
        if (clk_bps) begin
          if (!rxd) begin
            state_d = StData;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
            bps_d   = 1'b0;
          end
        end
      end
      StData: begin
        if (clk_bps) begin
          shift_d = {rxd, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (clk_bps) begin
          perr_d  = calc_perr(8'(shift_q), rxd, PARITY_ODD != 0);
          state_d = StStop;
        end
      end
      StStop: begin
        if (clk_bps) begin
          if (rxd) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q & (PARITY_EN != 0);
          end else begin
            ferr_d = 1'b1;
          end
          state_d = StIdle;
          bps_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        bps_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      bps_q      <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      bps_q      <= bps_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
    end
  end

  assign bps_start  = bps_q;
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_out_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8N1 instance and an even-parity instance, each
// fed by a small baud model (16 clk per bit, clk_bps when the count reaches 7).
module tb_uart_rx_frame;

  logic clk = 1'b0;
  logic rst;
  logic pin_a, pin_p;

  always #5 clk = ~clk;

  logic       bps_a, valid_a, ferr_a, perr_a, busy_a, clk_bps_a;
  logic [7:0] data_a;
  logic       bps_p, valid_p, ferr_p, perr_p, busy_p, clk_bps_p;
  logic [7:0] data_p;

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (pin_a),
    .clk_bps    (clk_bps_a),
    .bps_start  (bps_a),
    .rx_data    (data_a),
    .rx_valid   (valid_a),
    .frame_err  (ferr_a),
    .parity_err (perr_a),
    .rx_busy    (busy_a)
  );

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (pin_p),
    .clk_bps    (clk_bps_p),
    .bps_start  (bps_p),
    .rx_data    (data_p),
    .rx_valid   (valid_p),
    .frame_err  (ferr_p),
    .parity_err (perr_p),
    .rx_busy    (busy_p)
  );

  // Baud generator model: counter held at 0 while bps_start is low.
  logic [3:0] cnt_a, cnt_p;
  always @(posedge clk) begin
    cnt_a <= (rst || !bps_a) ? 4'd0 : cnt_a + 4'd1;
    cnt_p <= (rst || !bps_p) ? 4'd0 : cnt_p + 4'd1;
  end
  assign clk_bps_a = bps_a && (cnt_a == 4'd7);
  assign clk_bps_p = bps_p && (cnt_p == 4'd7);

  int         n_valid_a = 0, n_ferr_a = 0, n_valid_p = 0, n_perr_p = 0, n_ferr_p = 0;
  int         n_perr_a = 0;
  logic [7:0] last_a = 8'h00, prev_a = 8'h00, last_p = 8'h00;
  logic       bps_at_pulse_a = 1'b1;
  logic       busy_seen_a = 1'b0;

  always @(negedge clk) begin
    if (valid_a) begin
      n_valid_a++;
      prev_a = last_a;
      last_a = data_a;
      bps_at_pulse_a = bps_a;
    end
    if (ferr_a) begin
      n_ferr_a++;
      bps_at_pulse_a = bps_a;
    end
    if (perr_a) n_perr_a++;
    if (busy_a) busy_seen_a = 1'b1;
    if (valid_p) begin
      n_valid_p++;
      last_p = data_p;
    end
    if (perr_p) n_perr_p++;
    if (ferr_p) n_ferr_p++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) pin_p = b;
    else pin_a = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit use_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
    if (use_par) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
  endtask

  int v0, f0, p0, pf0;

  initial begin
    rst   = 1'b1;
    pin_a = 1'b1;
    pin_p = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_rx_data", data_a, 8'h00);
    check_eq("reset_rx_valid", valid_a, 1'b0);
    check_eq("reset_bps_start", bps_a, 1'b0);
    check_eq("reset_rx_busy", busy_a, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    v0 = n_valid_a; f0 = n_ferr_a;
    bps_at_pulse_a = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("a5_valid_count", n_valid_a - v0, 1);
    check_eq("a5_rx_data", last_a, 8'hA5);
    check_eq("a5_frame_err", n_ferr_a - f0, 0);
    check_eq("a5_bps_dropped", bps_at_pulse_a, 1'b0);
    check_eq("a5_bps_idle", bps_a, 1'b0);

    // Back-to-back 0x00, 0xFF
    v0 = n_valid_a;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("b2b_valid_count", n_valid_a - v0, 2);
    check_eq("b2b_first", prev_a, 8'h00);
    check_eq("b2b_second", last_a, 8'hFF);

    // Start glitch of 4 clk
    v0 = n_valid_a; f0 = n_ferr_a;
    busy_seen_a = 1'b0;
    pin_a = 1'b0;
    repeat (4) @(negedge clk);
    pin_a = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_entered_start", busy_seen_a, 1'b1);
    check_eq("glitch_no_pulse", (n_valid_a - v0) + (n_ferr_a - f0), 0);
    check_eq("glitch_bps_start", bps_a, 1'b0);
    check_eq("glitch_rx_busy", busy_a, 1'b0);

    // Stop bit low on 0x3C
    v0 = n_valid_a; f0 = n_ferr_a;
    bps_at_pulse_a = 1'b1;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    pin_a = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("ferr_count", n_ferr_a - f0, 1);
    check_eq("ferr_no_valid", n_valid_a - v0, 0);
    check_eq("ferr_data_held", data_a, 8'hFF);
    check_eq("ferr_bps_dropped", bps_at_pulse_a, 1'b0);
    check_eq("ferr_idle", busy_a, 1'b0);

    // Even parity on 0x07
    v0 = n_valid_p; p0 = n_perr_p; pf0 = n_ferr_p;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("par_ok_valid", n_valid_p - v0, 1);
    check_eq("par_ok_data", last_p, 8'h07);
    check_eq("par_ok_perr", n_perr_p - p0, 0);

    v0 = n_valid_p; p0 = n_perr_p;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("par_bad_valid", n_valid_p - v0, 1);
    check_eq("par_bad_perr", n_perr_p - p0, 1);
    check_eq("par_no_ferr", n_ferr_p - pf0, 0);

    // Reset during 4th data bit of 0x55 (bits so far: 1,0,1; 4th bit is 0)
    v0 = n_valid_a; f0 = n_ferr_a;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    pin_a = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    pin_a = 1'b1;
    check_eq("rst_mid_busy", busy_a, 1'b0);
    check_eq("rst_mid_bps", bps_a, 1'b0);
    repeat (40) @(negedge clk);
    check_eq("rst_mid_no_pulse", (n_valid_a - v0) + (n_ferr_a - f0), 0);

    v0 = n_valid_a;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("post_rst_valid", n_valid_a - v0, 1);
    check_eq("post_rst_data", data_a, 8'h55);
    check_eq("no_parity_err_8n1", n_perr_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
